// File: rtl/pram_ctrl_if.sv
// Bus bundle between the loader/fetch requesters, the program RAM and pram_ctrl.
// The master side drives requests and mem_rdata; the controller is the slave.
interface pram_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_busy;
    logic          f_valid;
    logic [DW-1:0] f_b0;
    logic [DW-1:0] f_b1;
    logic [DW-1:0] f_b2;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output ld_req, ld_addr, ld_data, f_req, f_addr, mem_rdata,
        input  ld_ack, f_busy, f_valid, f_b0, f_b1, f_b2,
               mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  ld_req, ld_addr, ld_data, f_req, f_addr, mem_rdata,
        output ld_ack, f_busy, f_valid, f_b0, f_b1, f_b2,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pram_ctrl.sv
// Program RAM port sequencer/arbiter: single-byte loader writes, 3-byte fetch reads.
// PRAM_CTRL_RR_EN selects round-robin arbitration instead of fixed loader priority.
module pram_ctrl #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rst,
    pram_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD1,
        RD2,
        RD3,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] a;
    logic          grant_ld;
    logic          grant_f;

`ifdef PRAM_CTRL_RR_EN
    // last_ld = 1 after a write grant; 0 (fetch) out of reset so the loader wins first
    logic last_ld;

    always_comb begin
        grant_ld = bus.ld_req && (!bus.f_req || !last_ld);
        grant_f  = bus.f_req && !grant_ld;
    end
`else
    always_comb begin
        grant_ld = bus.ld_req;
        grant_f  = bus.f_req && !bus.ld_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a             <= '0;
            bus.ld_ack    <= 1'b0;
            bus.f_busy    <= 1'b0;
            bus.f_valid   <= 1'b0;
            bus.f_b0      <= '0;
            bus.f_b1      <= '0;
            bus.f_b2      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef PRAM_CTRL_RR_EN
            last_ld       <= 1'b0;
`endif
        end else begin
            bus.ld_ack  <= 1'b0;
            bus.f_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.f_busy <= grant_f;
                    if (grant_ld) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.ld_addr;
                        bus.mem_wdata <= bus.ld_data;
                        bus.ld_ack    <= 1'b1;
                        state         <= WRITE;
`ifdef PRAM_CTRL_RR_EN
                        last_ld       <= 1'b1;
`endif
                    end else if (grant_f) begin
                        a            <= bus.f_addr;
                        bus.mem_addr <= bus.f_addr;
                        state        <= RD1;
`ifdef PRAM_CTRL_RR_EN
                        last_ld      <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    state      <= IDLE;
                end
                RD1: begin
                    bus.mem_addr <= a + AW'(1);
                    state        <= RD2;
                end
                // Read data lags the registered address by one cycle, so each
                // capture takes the byte addressed two states earlier.
                RD2: begin
                    bus.f_b0     <= bus.mem_rdata;
                    bus.mem_addr <= a + AW'(2);
                    state        <= RD3;
                end
                RD3: begin
                    bus.f_b1 <= bus.mem_rdata;
                    state    <= DONE;
                end
                DONE: begin
                    bus.f_b2    <= bus.mem_rdata;
                    bus.f_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    bus.mem_we <= 1'b0;
                    bus.f_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pram_ctrl.sv
// Directed bench for pram_ctrl with a 512x8 synchronous-read RAM model.
// Expectations adapt to PRAM_CTRL_RR_EN for the sustained-contention window.
module tb_pram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pram_ctrl_if #(.AW(9), .DW(8)) bus ();

    pram_ctrl #(.AW(9), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:511];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] addr, input logic [7:0] data);
        int n;
        bus.ld_req  = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ld_ack && n < 20);
        check("wr_ack", 32'(bus.ld_ack), 32'd1);
        check("wr_we", 32'(bus.mem_we), 32'd1);
        check("wr_addr", 32'(bus.mem_addr), 32'(addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(data));
        bus.ld_req = 1'b0;
        tick();
        check("wr_ack_drop", 32'(bus.ld_ack), 32'd0);
        check("wr_we_drop", 32'(bus.mem_we), 32'd0);
        check("wr_data_hold", 32'(bus.mem_wdata), 32'(data));
    endtask

    task automatic wait_fetch_grant();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.f_busy && n < 20);
        check("f_grant", 32'(bus.f_busy), 32'd1);
    endtask

    // Called just after the grant edge; runs the fetch through f_valid.
    task automatic finish_fetch(input logic [8:0] a, input logic [7:0] e0,
                                input logic [7:0] e1, input logic [7:0] e2,
                                input bit chk_all, input bit drop);
        int n;
        logic [8:0] a1, a2;
        a1 = a + 9'd1;
        a2 = a + 9'd2;
        check("f_addr0", 32'(bus.mem_addr), 32'(a));
        n = 0;
        while (!bus.f_valid && n < 10) begin
            tick();
            n++;
            if (n == 1) check("f_addr1", 32'(bus.mem_addr), 32'(a1));
            if (n == 2) check("f_addr2", 32'(bus.mem_addr), 32'(a2));
            if (n < 4) check("f_rd_we", 32'(bus.mem_we), 32'd0);
        end
        check("f_latency", 32'(n), 32'd4);
        check("f_busy_valid", 32'(bus.f_busy), 32'd1);
        check("f_b0", 32'(bus.f_b0), 32'(e0));
        if (chk_all) begin
            check("f_b1", 32'(bus.f_b1), 32'(e1));
            check("f_b2", 32'(bus.f_b2), 32'(e2));
        end
        if (drop) begin
            bus.f_req = 1'b0;
            tick();
            check("f_valid_drop", 32'(bus.f_valid), 32'd0);
            check("f_busy_drop", 32'(bus.f_busy), 32'd0);
        end
    endtask

    initial begin
        int acks, valids;

        // Reset held 2 cycles with both requests high
        bus.ld_req  = 1'b1;
        bus.ld_addr = 9'h010;
        bus.ld_data = 8'hA1;
        bus.f_req   = 1'b1;
        bus.f_addr  = 9'h010;
        tick();
        tick();
        check("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
        check("rst_f_valid", 32'(bus.f_valid), 32'd0);
        check("rst_f_busy", 32'(bus.f_busy), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_bytes", {8'd0, bus.f_b0, bus.f_b1, bus.f_b2}, 32'd0);
        rst = 1'b0;

        // First edge after reset: loader wins the simultaneous request
        tick();
        check("cont_ld_first", 32'(bus.ld_ack), 32'd1);
        check("cont_f_pending", 32'(bus.f_busy), 32'd0);
        check("cont_wr_addr", 32'(bus.mem_addr), 32'h010);
        bus.ld_req = 1'b0;
        tick();
        check("cont_write_cyc", {bus.ld_ack, bus.mem_we, bus.f_busy}, 32'd0);
        tick();
        check("cont_f_after_wr", 32'(bus.f_busy), 32'd1);
        finish_fetch(9'h010, 8'hA1, 8'h00, 8'h00, 1'b0, 1'b1);

        do_write(9'h011, 8'hB2);
        do_write(9'h012, 8'hC3);
        do_write(9'h020, 8'h5A);
        do_write(9'h021, 8'h6B);
        do_write(9'h022, 8'h7C);

        // Back-to-back fetch; f_addr change after grant must not affect the first
        bus.f_req  = 1'b1;
        bus.f_addr = 9'h010;
        wait_fetch_grant();
        bus.f_addr = 9'h020;
        finish_fetch(9'h010, 8'hA1, 8'hB2, 8'hC3, 1'b1, 1'b0);
        tick();
        check("b2b_grant_e5", {bus.f_busy, bus.f_valid}, 32'b10);
        finish_fetch(9'h020, 8'h5A, 8'h6B, 8'h7C, 1'b1, 1'b1);

        // Address wrap at 0x1FF
        do_write(9'h1FF, 8'h11);
        do_write(9'h000, 8'h22);
        do_write(9'h001, 8'h33);
        bus.f_req  = 1'b1;
        bus.f_addr = 9'h1FF;
        wait_fetch_grant();
        finish_fetch(9'h1FF, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1);

        // Sustained contention over a 14-cycle window
        bus.ld_req  = 1'b1;
        bus.ld_addr = 9'h100;
        bus.ld_data = 8'h99;
        bus.f_req   = 1'b1;
        bus.f_addr  = 9'h010;
        acks   = 0;
        valids = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.ld_ack) acks++;
            if (bus.f_valid) valids++;
        end
        bus.ld_req = 1'b0;
        bus.f_req  = 1'b0;
`ifdef PRAM_CTRL_RR_EN
        check("rr_acks", 32'(acks), 32'd2);
        check("rr_valids", 32'(valids), 32'd2);
        check("rr_last_b0", 32'(bus.f_b0), 32'hA1);
`else
        check("fixed_acks", 32'(acks), 32'd7);
        check("fixed_starved", 32'(valids), 32'd0);
`endif
        tick();
        check("window_quiet", {bus.ld_ack, bus.f_busy, bus.mem_we}, 32'd0);

        // Reset during RD2 aborts the fetch
        bus.f_req  = 1'b1;
        bus.f_addr = 9'h010;
        wait_fetch_grant();
        tick();
        rst       = 1'b1;
        bus.f_req = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.f_busy), 32'd0);
        check("abort_addr", 32'(bus.mem_addr), 32'd0);
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.f_valid) valids++;
        end
        check("abort_no_valid", 32'(valids), 32'd0);
        check("abort_b0", 32'(bus.f_b0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pram_ctrl.md
# pram_ctrl

Sequencer and arbiter that owns the single port of the 512×8 program RAM and shares it between two requesters: the program loader, which writes single bytes, and the instruction fetch unit, which reads one 3-byte instruction. Each fetch is issued as three back-to-back synchronous reads from A, A+1 and A+2, and the bytes come back as one bundle with a valid pulse. The block sits between the loader/fetch logic and the raw memory array.

## Interface
- AW, 9, memory address width (512 locations)
- DW, 8, memory data width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- ld_req  in  1  loader write request, level; held until ld_ack
- ld_addr  in  AW  loader write address
- ld_data  in  DW  loader write data
- ld_ack  out  1  one-cycle pulse: write granted and issued
- f_req  in  1  fetch request, level; held until f_valid
- f_addr  in  AW  instruction address A; latched at grant
- f_busy  out  1  fetch in progress, from grant through the f_valid cycle
- f_valid  out  1  one-cycle pulse: f_b0/f_b1/f_b2 are valid
- f_b0, f_b1, f_b2  out  DW each  opcode and operand bytes mem[A], mem[A+1], mem[A+2]
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_rdata  in  DW  memory read data; synchronous, 1-cycle read latency

## Operation
- States:
  - IDLE: arbitrate.
  - WRITE: one cycle with mem_we=1.
  - RD1, RD2, RD3: issue reads and capture bytes.
  - DONE: f_valid=1.
- Arbitration happens only in IDLE. An operation in progress is never pre-empted.
- Default priority is fixed: when both requesters are high, the loader wins. The fetch stays pending.
- Write grant:
  - Registers mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data; ld_ack=1.
  - Goes to WRITE. WRITE drops mem_we, then returns to IDLE.
- Fetch grant:
  - Latches A=f_addr, registers mem_addr=A, sets f_busy, goes to RD1.
  - RD1: mem_addr←A+1.
  - RD2: f_b0←mem_rdata; mem_addr←A+2.
  - RD3: f_b1←mem_rdata.
  - Then DONE: f_b2←mem_rdata captured, f_valid=1, f_busy=1.
  - DONE goes to IDLE.
- Address arithmetic is AW-bit modulo 512. Example: A=0x1FF reads 0x1FF, 0x000, 0x001.
- mem_we is 0 in every read state. mem_wdata holds its last value when not writing.
- f_b0/f_b1/f_b2 hold their values until the next completed fetch overwrites them.
- Requester rules:
  - The loader drops or changes ld_req in the cycle ld_ack is high.
  - The fetch unit drops f_req in the cycle f_valid is high.
  - A request still high at that edge is treated as a new request. This gives back-to-back operation.
- Changes to f_addr after grant are ignored.

## Timing
- Reset (sync, rst=1 at an edge):
  - State goes to IDLE.
  - ld_ack, f_valid, f_busy, mem_we are 0.
  - mem_addr, mem_wdata, f_b0..f_b2 are 0.
  - Any pending A is discarded.
- Reset mid-fetch aborts the fetch: no f_valid, no partial byte update after the reset edge.
- Reset mid-write drops mem_we at that edge.
- Write: ld_req sampled at edge E0 gives ld_ack and mem_we high during E0→E1. The memory commits at E1.
  - Maximum throughput is one write per 2 cycles.
- Fetch: grant at edge E0 gives f_valid high during E4→E5. That is 4 cycles of latency and 5 cycles of f_busy.
  - A back-to-back fetch is granted at E5, which gives one instruction per 5 cycles.
- With both requests high continuously under fixed priority, a fetch waits for every loader write. Starvation is permitted in fixed mode.

## Configuration
- PRAM_CTRL_RR_EN defined:
  - Round-robin arbitration. A 1-bit last-grant register (reset to "fetch") gives the loader priority after a fetch and the fetch priority after a write, when both are requesting.
  - A sole requester is always granted.
- Undefined: fixed loader-over-fetch priority as above, and no last-grant register.

## Test plan
- Reset: drive rst for 2 cycles with requests high → every output is 0. The first grant happens on the first edge after rst falls.
- Write then fetch:
  - Write 0xA1, 0xB2, 0xC3 to 0x010..0x012 → each ld_ack is one cycle, with mem_we/mem_addr matching.
  - Then fetch f_addr=0x010 → f_valid exactly 4 cycles after grant, with f_b0=0xA1, f_b1=0xB2, f_b2=0xC3.
- Wrap: preload 0x1FF=0x11, 0x000=0x22, 0x001=0x33; fetch 0x1FF → mem_addr sequence 0x1FF, 0x000, 0x001; bytes 0x11/0x22/0x33.
- Contention:
  - ld_req and f_req rise together → loader granted first; the fetch is granted on the edge after WRITE.
  - With PRAM_CTRL_RR_EN and both held high → grants alternate fetch/write.
- Reset mid-fetch: assert rst in RD2 → f_valid never pulses; f_b0 keeps its reset value 0.
- Back-to-back fetch: hold f_req through f_valid with f_addr changed to 0x020 → the second fetch is granted at E5 and returns mem[0x020..0x022].
